adc_spi_writer: RTL

Serial register-access controller for the front-end ADCs' configuration port. It runs on the 10 MHz configuration clock and shifts 24-bit frames (R/W, 2 width bits, 13-bit address, 8 data bits) out MSB first. It drives `adcsclk_disable` to the ADC clock block, which gates the `sclk` ODDR, together with per-ADC chip selects and SDIO. Slow-control logic issues one register access per request/done handshake.

---
 rtl/adc_spi_pkg.sv | 41 ++++
 rtl/adc_spi_writer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and frame layout for the ADC configuration-port
// serialiser (adc_spi_writer).
//   - state_e        : controller FSM states
//   - FRAME_W/ADDR_W : frame and address widths
//   - field positions and build_frame() helper for the 24-bit SPI frame
package adc_spi_pkg;

  localparam int FRAME_W  = 24;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 8;

  // Frame layout: {rnw, width[1:0], addr[12:0], data[7:0]}, sent MSB first.
  localparam int RNW_POS  = 23;
  localparam int W_MSB    = 22;
  localparam int W_LSB    = 21;
  localparam int ADDR_MSB = 20;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Width field is always 2'b00: single-byte access.
  function automatic logic [FRAME_W-1:0] build_frame(input logic              rnw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[RNW_POS]           = rnw;
    f[W_MSB:W_LSB]       = 2'b00;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:0]        = data;
    return f;
  endfunction

endpackage

// File: rtl/adc_spi_writer.sv
// adc_spi_writer: register-access controller for the ADC configuration port.
// One 24-bit frame per req/done handshake, shifted MSB first at clk/2.
// Optional feature macro: ADC_SPI_READBACK_EN (read transactions; sdio turnaround
// during bits 7..0 and capture of sdio_in into rdata).
// Ports:
//   clk, rst            : 10 MHz config clock, synchronous active-high reset
//   req/rnw/addr/wdata  : request (sampled in IDLE only), cs_mask selects ADCs
//   busy, done, rdata   : status; done is a one-cycle pulse, rdata held until next accept
//   adcsclk_disable     : sclk gate; 0 => one sclk pulse in the following cycle
//   csb, sdio_out/oe/in : active-low chip selects and SDIO pad signals
module adc_spi_writer
  import adc_spi_pkg::*;
#(
  parameter int NUM_ADC    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               rnw,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [NUM_ADC-1:0] cs_mask,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rdata,
  output logic               adcsclk_disable,
  output logic [NUM_ADC-1:0] csb,
  output logic               sdio_out,
  output logic               sdio_oe,
  input  logic               sdio_in
);

  // Counter also times the 2-cycle HOLD, so it needs at least 1 bit.
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [4:0]         bit_q, bit_d;
  logic               ph_q, ph_d;
  logic [GW-1:0]      cnt_q, cnt_d;
  logic [NUM_ADC-1:0] mask_q, mask_d;
  logic               rnw_q, rnw_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic rnw_eff;  // rnw as seen by the frame builder
  logic cap_bit;  // bit shifted into the LSB of the shift register

`ifdef ADC_SPI_READBACK_EN
  assign rnw_eff = rnw;
  // ADC drives read data during bits 7..0; sampled at the end of each phase 1.
  assign cap_bit = rnw_q && (bit_q < 5'd8) && sdio_in;
`else
  logic unused_inputs;
  assign rnw_eff       = 1'b0;
  assign cap_bit       = 1'b0;
  assign unused_inputs = ^{sdio_in, rnw};
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    rnw_d   = rnw_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && (|cs_mask)) begin
          sh_d    = build_frame(rnw_eff, addr, wdata);
          mask_d  = cs_mask;
          rnw_d   = rnw_eff;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        bit_d   = 5'd23;
        ph_d    = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          // Advance only after the rising sclk edge of phase 1 has passed.
          ph_d = 1'b0;
          sh_d = {sh_q[FRAME_W-2:0], cap_bit};
          if (bit_q == 5'd0) begin
            cnt_d   = GW'(1);
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = GW'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - GW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef ADC_SPI_READBACK_EN
          if (rnw_q) rdata_d = sh_q[DATA_W-1:0];
`endif
        end else begin
          cnt_d = cnt_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      rnw_q   <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rnw_q   <= rnw_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are decoded from registered state only, so they follow reset on
  // the very next edge.
  logic frame_act;
  assign frame_act       = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                           (state_q == ST_HOLD);
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign rdata           = rdata_q;
  assign csb             = frame_act ? ~mask_q : '1;
  assign adcsclk_disable = !((state_q == ST_SHIFT) && !ph_q);
  assign sdio_out        = ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) ?
                           sh_q[FRAME_W-1] : 1'b0;
`ifdef ADC_SPI_READBACK_EN
  assign sdio_oe = !(rnw_q && (((state_q == ST_SHIFT) && (bit_q < 5'd8)) ||
                               (state_q == ST_HOLD)));
`else
  assign sdio_oe = 1'b1;
`endif

endmodule
